network_source_sched: RTL and testbench

NETWORK_SOURCE_SCHED -- requirements
Module: network_source_sched

---
 rtl/network_source_sched_pkg.sv | 42 ++++
 rtl/network_source_sched_if.sv | 29 ++
 rtl/prdc_channel.sv | 55 +++++
 rtl/network_source_sched.sv | 154 +++++++++++++++
 tb/tb_network_source_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/network_source_sched_pkg.sv
// rtl/network_source_sched_pkg.sv - opcodes, field widths and command-width derivation for the source scheduler
package source_sched_config;

    localparam int OPC_WIDTH = 3;

    typedef enum logic [OPC_WIDTH-1:0] {
        OPC_NOP       = 3'd0,
        OPC_RUN       = 3'd1,
        OPC_SPK       = 3'd2,
        OPC_CLR       = 3'd3,
        OPC_SPK_PRDC  = 3'd4,
        OPC_PRDC_STOP = 3'd5
    } opcode_t;

    localparam int DEF_NUM_INP      = 4;
    localparam int DEF_CHARGE_WIDTH = 8;
    localparam int DEF_RUN_WIDTH    = 16;
    localparam int DEF_MAX_PERIOD   = 255;
    localparam int DEF_CNT_W        = 8;

    function automatic int idx_w(input int num_inp);
        return (num_inp > 1) ? $clog2(num_inp) : 1;
    endfunction

    function automatic int prd_w(input int max_period);
        return $clog2(max_period + 1);
    endfunction

    // Widest command is either RUN or SPK_PRDC depending on parameters.
    function automatic int src_width(input int num_inp, input int charge_w, input int run_w,
                                     input int max_period, input int cnt_w);
        int run_len;
        int prdc_len;
        run_len  = OPC_WIDTH + run_w;
        prdc_len = OPC_WIDTH + idx_w(num_inp) + charge_w + prd_w(max_period) + cnt_w;
        return (run_len > prdc_len) ? run_len : prdc_len;
    endfunction

    localparam int DEF_SRC_WIDTH = src_width(DEF_NUM_INP, DEF_CHARGE_WIDTH, DEF_RUN_WIDTH,
                                             DEF_MAX_PERIOD, DEF_CNT_W);

endpackage

// File: rtl/network_source_sched_if.sv
// rtl/network_source_sched_if.sv - command and network-step handshake bundle
interface network_source_sched_if
    import source_sched_config::*;
#(
    parameter int NUM_INP      = DEF_NUM_INP,
    parameter int CHARGE_WIDTH = DEF_CHARGE_WIDTH,
    parameter int SRC_WIDTH    = DEF_SRC_WIDTH
) ();

    logic                                   src_valid;
    logic                                   src_ready;
    logic [SRC_WIDTH-1:0]                   src;
    logic                                   net_valid;
    logic                                   net_ready;
    logic                                   net_arstn;
    logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]   net_inp;
    logic [NUM_INP-1:0]                     prdc_active;

    modport master (
        output src_valid, src, net_ready,
        input  src_ready, net_valid, net_arstn, net_inp, prdc_active
    );

    modport slave (
        input  src_valid, src, net_ready,
        output src_ready, net_valid, net_arstn, net_inp, prdc_active
    );

endinterface

// File: rtl/prdc_channel.sv
// rtl/prdc_channel.sv - one periodic stimulus channel: phase counter, repeat budget and due flag
module prdc_channel #(
    parameter int PRD_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             load,
    input  logic             stop,
    input  logic             step,
    input  logic [PRD_W-1:0] period,
    input  logic [CNT_W-1:0] count,
    output logic             enabled,
    output logic             due
);

    logic [PRD_W-1:0] period_r;
    logic [PRD_W-1:0] phase;
    logic [CNT_W-1:0] remaining;
    logic             unlimited;

    assign due = enabled && (phase == '0);

    // A command on this channel takes precedence over a coincident step.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            enabled   <= 1'b0;
            period_r  <= '0;
            phase     <= '0;
            remaining <= '0;
            unlimited <= 1'b0;
        end else if (clr) begin
            enabled <= 1'b0;
            phase   <= '0;
        end else if (load) begin
            enabled   <= (period != '0);
            period_r  <= period;
            phase     <= '0;
            remaining <= count;
            unlimited <= (count == '0);
        end else if (stop) begin
            enabled <= 1'b0;
        end else if (step && enabled) begin
            phase <= (phase == period_r - PRD_W'(1)) ? '0 : phase + PRD_W'(1);
            if (due && !unlimited) begin
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    enabled <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/network_source_sched.sv
// rtl/network_source_sched.sv - decodes source commands into per-step network input charges
module network_source_sched
    import source_sched_config::*;
#(
    parameter int NUM_INP      = DEF_NUM_INP,
    parameter int CHARGE_WIDTH = DEF_CHARGE_WIDTH,
    parameter int RUN_WIDTH    = DEF_RUN_WIDTH,
    parameter int MAX_PERIOD   = DEF_MAX_PERIOD,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SRC_WIDTH    = src_width(NUM_INP, CHARGE_WIDTH, RUN_WIDTH, MAX_PERIOD, CNT_W)
) (
    input  logic                   clk,
    input  logic                   arstn,
    network_source_sched_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_INP);
    localparam int PRD_W = prd_w(MAX_PERIOD);
    localparam int F_TOP = SRC_WIDTH - OPC_WIDTH;

    localparam logic signed [CHARGE_WIDTH-1:0] CH_MAX = {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
    localparam logic signed [CHARGE_WIDTH-1:0] CH_MIN = {1'b1, {(CHARGE_WIDTH-1){1'b0}}};

    function automatic logic signed [CHARGE_WIDTH-1:0] sat_add(
        input logic signed [CHARGE_WIDTH-1:0] a,
        input logic signed [CHARGE_WIDTH-1:0] b
    );
        logic signed [CHARGE_WIDTH:0] s;
        s = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};
        if (s[CHARGE_WIDTH] != s[CHARGE_WIDTH-1]) begin
            return s[CHARGE_WIDTH] ? CH_MIN : CH_MAX;
        end
        return s[CHARGE_WIDTH-1:0];
    endfunction

    // Fields are packed MSB-first directly below the opcode.
    logic [OPC_WIDTH-1:0]           opc_raw;
    logic [RUN_WIDTH-1:0]           f_n;
    logic [IDX_W-1:0]               f_idx;
    logic signed [CHARGE_WIDTH-1:0] f_val;
    logic [PRD_W-1:0]               f_period;
    logic [CNT_W-1:0]               f_count;

    assign opc_raw  = bus.src[SRC_WIDTH-1 -: OPC_WIDTH];
    assign f_n      = bus.src[F_TOP-1 -: RUN_WIDTH];
    assign f_idx    = bus.src[F_TOP-1 -: IDX_W];
    assign f_val    = bus.src[F_TOP-IDX_W-1 -: CHARGE_WIDTH];
    assign f_period = bus.src[F_TOP-IDX_W-CHARGE_WIDTH-1 -: PRD_W];
    assign f_count  = bus.src[F_TOP-IDX_W-CHARGE_WIDTH-PRD_W-1 -: CNT_W];

    logic [RUN_WIDTH-1:0] run_ctr;
    logic                 src_ready;
    logic                 net_valid;
    logic                 step;
    logic                 cmd_acc;
    logic                 idx_ok;
    opcode_t              opc;

    assign src_ready     = (run_ctr <= RUN_WIDTH'(1));
    assign net_valid     = (run_ctr != '0);
    assign step          = net_valid && bus.net_ready;
    assign cmd_acc       = bus.src_valid && src_ready;
    assign idx_ok        = (32'(f_idx) < NUM_INP);
    assign bus.src_ready = src_ready;
    assign bus.net_valid = net_valid;

    always_comb begin
        opc = OPC_NOP;
        if (cmd_acc) begin
            case (opc_raw)
                OPC_RUN, OPC_SPK, OPC_CLR, OPC_SPK_PRDC, OPC_PRDC_STOP: opc = opcode_t'(opc_raw);
                default: opc = OPC_NOP;
            endcase
        end
    end

    // A RUN load overrides a coincident step decrement.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            run_ctr <= '0;
        end else if (opc == OPC_CLR) begin
            run_ctr <= '0;
        end else if (opc == OPC_RUN) begin
            run_ctr <= (f_n == '0) ? RUN_WIDTH'(1) : f_n;
        end else if (step) begin
            run_ctr <= run_ctr - RUN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bus.net_arstn <= 1'b0;
        end else begin
            bus.net_arstn <= (opc != OPC_CLR);
        end
    end

    for (genvar i = 0; i < NUM_INP; i++) begin : g_inp
        logic signed [CHARGE_WIDTH-1:0] acc_r;
        logic signed [CHARGE_WIDTH-1:0] pval_r;
        logic                           hit;
        logic                           spk_hit;
        logic                           prdc_hit;
        logic                           stop_hit;
        logic                           due;

        assign hit      = idx_ok && (f_idx == IDX_W'(i));
        assign spk_hit  = hit && (opc == OPC_SPK);
        assign prdc_hit = hit && (opc == OPC_SPK_PRDC);
        assign stop_hit = hit && (opc == OPC_PRDC_STOP);

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                acc_r <= '0;
            end else if (opc == OPC_CLR) begin
                acc_r <= '0;
            end else if (spk_hit) begin
                acc_r <= sat_add(step ? '0 : acc_r, f_val);
            end else if (step) begin
                acc_r <= '0;
            end
        end

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                pval_r <= '0;
            end else if (opc == OPC_CLR || stop_hit) begin
                pval_r <= '0;
            end else if (prdc_hit && f_period != '0) begin
                pval_r <= f_val;
            end
        end

        prdc_channel #(
            .PRD_W (PRD_W),
            .CNT_W (CNT_W)
        ) u_prdc_channel (
            .clk     (clk),
            .arstn   (arstn),
            .clr     (opc == OPC_CLR),
            .load    (prdc_hit),
            .stop    (stop_hit),
            .step    (step),
            .period  (f_period),
            .count   (f_count),
            .enabled (bus.prdc_active[i]),
            .due     (due)
        );

        // A reprogram or stop on this channel suppresses the pulse it would have produced now.
        assign bus.net_inp[i] = sat_add(acc_r, (due && !prdc_hit && !stop_hit) ? pval_r : '0);
    end

endmodule

// File: tb/tb_network_source_sched.sv
// tb/tb_network_source_sched.sv - directed and randomized checks against a step-indexed reference model
module tb_network_source_sched;
    import source_sched_config::*;

    localparam int NI = 3;
    localparam int CW = 8;
    localparam int RW = 16;
    localparam int MP = 255;
    localparam int CN = 8;
    localparam int SW = src_width(NI, CW, RW, MP, CN);
    localparam int IW = 2;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    network_source_sched_if #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .SRC_WIDTH(SW)) bus ();

    network_source_sched #(
        .NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .MAX_PERIOD(MP), .CNT_W(CN), .SRC_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: pending charge per input, remaining RUN steps, and periodic
    // channels described by the global step index they start at plus pulses fired.
    int run_m;
    int pend [NI];
    bit en [NI];
    int pv [NI];
    int per [NI];
    int cnt [NI];
    int start [NI];
    int fired [NI];
    int gstep;
    bit arst_m;
    bit rnd_mode;

    int c_opc, c_idx, c_val, c_per, c_cnt, c_n;

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic bit due_m(input int i);
        return en[i] && (((gstep - start[i]) % per[i]) == 0);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        run_m = 0; gstep = 0; arst_m = 1'b0;
        for (int i = 0; i < NI; i++) begin
            pend[i] = 0; en[i] = 1'b0; pv[i] = 0; per[i] = 1; cnt[i] = 0; start[i] = 0; fired[i] = 0;
        end
    endtask

    task automatic model_edge(input bit acc, input bit stp);
        bit d [NI];
        for (int i = 0; i < NI; i++) d[i] = due_m(i);
        if (acc && c_opc == 3) begin
            run_m = 0; arst_m = 1'b0;
            for (int i = 0; i < NI; i++) begin pend[i] = 0; en[i] = 1'b0; pv[i] = 0; end
            return;
        end
        arst_m = 1'b1;
        if (acc && c_opc == 1) run_m = (c_n == 0) ? 1 : c_n;
        else if (stp) run_m--;
        for (int i = 0; i < NI; i++) begin
            if (acc && c_opc == 2 && c_idx == i) pend[i] = sat((stp ? 0 : pend[i]) + c_val);
            else if (stp) pend[i] = 0;
            if (acc && c_opc == 4 && c_idx == i) begin
                if (c_per == 0) en[i] = 1'b0;
                else begin
                    en[i] = 1'b1; pv[i] = c_val; per[i] = c_per; cnt[i] = c_cnt;
                    fired[i] = 0; start[i] = gstep + (stp ? 1 : 0);
                end
            end else if (acc && c_opc == 5 && c_idx == i) begin
                en[i] = 1'b0; pv[i] = 0;
            end else if (stp && d[i]) begin
                fired[i]++;
                if (cnt[i] != 0 && fired[i] == cnt[i]) en[i] = 1'b0;
            end
        end
        if (stp) gstep++;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit rdy, vld, acc, stp, g;
        int exp_i;
        #1;
        rdy = (run_m <= 1);
        vld = (run_m > 0);
        chk("src_ready", bus.src_ready, rdy);
        chk("net_valid", bus.net_valid, vld);
        chk("net_arstn", bus.net_arstn, arst_m);
        acc = bus.src_valid && rdy;
        stp = vld && bus.net_ready;
        for (int i = 0; i < NI; i++) begin
            g = acc && (c_opc == 4 || c_opc == 5) && c_idx == i;
            exp_i = sat(pend[i] + ((due_m(i) && !g) ? pv[i] : 0));
            chk($sformatf("net_inp[%0d]", i), $signed(bus.net_inp[i]), exp_i);
            chk($sformatf("prdc_active[%0d]", i), bus.prdc_active[i], en[i]);
        end
        @(posedge clk);
        model_edge(acc, stp);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            if (rnd_mode) bus.net_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
    endtask

    task automatic send(input int opc, input int idx, input int val, input int prd, input int count, input int n);
        logic [SW-1:0] w;
        bit done;
        w = '0;
        w[SW-1 -: 3] = 3'(opc);
        if (opc == 1) w[SW-4 -: RW] = RW'(n);
        else begin
            w[SW-4 -: IW]            = IW'(idx);
            w[SW-4-IW -: CW]         = CW'(val);
            w[SW-4-IW-CW -: PW]      = PW'(prd);
            w[SW-4-IW-CW-PW -: CN]   = CN'(count);
        end
        c_opc = opc; c_idx = idx; c_val = val; c_per = prd; c_cnt = count; c_n = n;
        bus.src = w;
        bus.src_valid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (rnd_mode) bus.net_ready = ($urandom_range(0, 3) != 0);
            done = (run_m <= 1);
            cycle();
        end
        chk("send_accepted_in_budget", done, 1);
        bus.src_valid = 1'b0;
        c_opc = 0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        #1;
        chk("rst_net_valid", bus.net_valid, 0);
        chk("rst_src_ready", bus.src_ready, 1);
        chk("rst_net_arstn", bus.net_arstn, 0);
        chk("rst_net_inp", bus.net_inp, 0);
        chk("rst_prdc_active", bus.prdc_active, 0);
        model_reset();
        repeat (2) @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        bus.src_valid = 1'b0;
        bus.src = '0;
        bus.net_ready = 1'b1;
        rnd_mode = 1'b0;
        c_opc = 0; c_idx = 0; c_val = 0; c_per = 0; c_cnt = 0; c_n = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Two +100 spikes saturate to 127 for a single step.
        send(2, 1, 100, 0, 0, 0);
        send(2, 1, 100, 0, 0, 0);
        send(1, 0, 0, 0, 0, 1);
        idx_check_127: begin
            #1;
            chk("spk_sat_127", $signed(bus.net_inp[1]), 127);
            @(negedge clk);
        end
        run_m = 0; pend[1] = 0; gstep++; arst_m = 1'b1;
        idle(3);

        // Periodic val 5, period 3, two pulses over a 10-step run.
        send(4, 0, 5, 3, 2, 0);
        send(1, 0, 0, 0, 0, 10);
        idle(12);

        // RUN 3 with a four-cycle stall mid-run.
        send(1, 0, 0, 0, 0, 3);
        cycle();
        bus.net_ready = 1'b0;
        idle(4);
        bus.net_ready = 1'b1;
        idle(4);

        // Unlimited period-2 channel stopped on a due step.
        send(4, 2, 7, 2, 0, 0);
        send(1, 0, 0, 0, 0, 3);
        send(5, 2, 0, 0, 0, 0);
        idle(3);

        // Out-of-range index is ignored.
        send(2, 3, 50, 0, 0, 0);
        send(4, 3, 9, 1, 0, 0);
        send(1, 0, 0, 0, 0, 1);
        idle(2);

        // CLR after setup.
        send(2, 0, -20, 0, 0, 0);
        send(4, 1, 9, 2, 0, 0);
        send(3, 0, 0, 0, 0, 0);
        idle(3);

        rnd_mode = 1'b1;
        for (int r = 0; r < 300; r++) begin
            send($urandom_range(0, 7), $urandom_range(0, 3), int'($signed(8'($urandom))),
                 $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 5));
            idle($urandom_range(0, 2));
        end
        rnd_mode = 1'b0;
        bus.net_ready = 1'b1;
        idle(8);

        // Reset mid-RUN abandons the remaining steps.
        send(1, 0, 0, 0, 0, 10);
        idle(3);
        do_reset();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
